// File: rtl/uart_tx_arbiter_if.sv
// Byte-source and uart_tx handshake bundle for the UART transmit arbiter.
// master: the arbiter side; slave: the requesters plus the uart_tx instance.
interface uart_tx_arbiter_if #(
    parameter int N_REQ = 4
);
    logic [N_REQ-1:0]   req_valid;
    logic [8*N_REQ-1:0] req_data;
    logic [N_REQ-1:0]   req_last;
    logic [N_REQ-1:0]   req_ready;
    logic               tx_start;
    logic [7:0]         tx_data;
    logic               tx_busy;
    logic               grant_valid;
    logic [1:0]         grant_id;
    logic               tx_err;

    modport master (
        input  req_valid, req_data, req_last, tx_busy,
        output req_ready, tx_start, tx_data, grant_valid, grant_id, tx_err
    );

    modport slave (
        output req_valid, req_data, req_last, tx_busy,
        input  req_ready, tx_start, tx_data, grant_valid, grant_id, tx_err
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin, packet-granular arbiter sharing one uart_tx among N_REQ byte sources.
//
// state        | meaning
// -------------+-----------------------------------------------------------------
// ST_IDLE      | no owner; grant first valid requester at/after rr_ptr once tx idle
// ST_LOAD      | owner's byte present: pulse tx_start/req_ready, capture byte
// ST_WAIT_BUSY | waiting up to BUSY_TMO cycles for uart_tx to raise tx_busy
// ST_WAIT_DONE | frame shifting; on completion decide release or keep the grant
// ST_GAP       | grant held for up to IDLE_TMO cycles waiting for the owner's next byte
// ST_RELEASE   | one cycle with grant dropped; rr_ptr moves past the old owner
module uart_tx_arbiter #(
    parameter int N_REQ     = 4,
    parameter int MAX_BURST = 16,
    parameter int IDLE_TMO  = 1024,
    parameter int BUSY_TMO  = 4
) (
    input logic               sclk,
    input logic               reset,
    uart_tx_arbiter_if.master bus
);
    localparam int TMO_MAX = (IDLE_TMO > BUSY_TMO) ? IDLE_TMO : BUSY_TMO;
    localparam int TW      = $clog2(TMO_MAX + 1);
    localparam logic [TW-1:0] BUSY_LD = TW'(BUSY_TMO - 1);
    localparam logic [TW-1:0] IDLE_LD = TW'(IDLE_TMO - 1);
    localparam logic [7:0]    MAX_B   = 8'(MAX_BURST);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_WAIT_BUSY,
        ST_WAIT_DONE,
        ST_GAP,
        ST_RELEASE
    } state_t;

    state_t           state_q, state_d;
    logic [1:0]       rr_ptr_q, rr_ptr_d;
    logic [1:0]       grant_id_q, grant_id_d;
    logic             grant_valid_q, grant_valid_d;
    logic [7:0]       burst_cnt_q, burst_cnt_d;
    logic [TW-1:0]    timer_q, timer_d;
    logic             last_f_q, last_f_d;
    logic             tx_start_q, tx_start_d;
    logic [7:0]       tx_data_q, tx_data_d;
    logic [N_REQ-1:0] req_ready_q, req_ready_d;
    logic             tx_err_q, tx_err_d;

    logic [7:0] req_byte [N_REQ];
    logic       pick_found;
    logic [1:0] pick_id;
    logic [1:0] cand;

    for (genvar i = 0; i < N_REQ; i++) begin : g_byte
        assign req_byte[i] = bus.req_data[8*i+7:8*i];
    end

    // Round-robin search: first valid requester at or after rr_ptr, wrapping.
    always_comb begin
        pick_found = 1'b0;
        pick_id    = '0;
        cand       = '0;
        for (int k = 0; k < N_REQ; k++) begin
            cand = 2'((int'(rr_ptr_q) + k) % N_REQ);
            if (!pick_found && bus.req_valid[cand]) begin
                pick_found = 1'b1;
                pick_id    = cand;
            end
        end
    end

    // Next-state and registered-output decode; pulses default low every cycle.
    always_comb begin
        state_d       = state_q;
        rr_ptr_d      = rr_ptr_q;
        grant_id_d    = grant_id_q;
        grant_valid_d = grant_valid_q;
        burst_cnt_d   = burst_cnt_q;
        timer_d       = timer_q;
        last_f_d      = last_f_q;
        tx_start_d    = 1'b0;
        tx_data_d     = tx_data_q;
        req_ready_d   = '0;
        tx_err_d      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // A frame started by someone else (or left over from before a
                // reset) must finish before the transmitter is handed out.
                if (!bus.tx_busy && pick_found) begin
                    grant_id_d    = pick_id;
                    grant_valid_d = 1'b1;
                    burst_cnt_d   = '0;
                    state_d       = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (bus.req_valid[grant_id_q]) begin
                    tx_start_d              = 1'b1;
                    req_ready_d[grant_id_q] = 1'b1;
                    tx_data_d               = req_byte[grant_id_q];
                    last_f_d                = bus.req_last[grant_id_q];
                    if (burst_cnt_q != MAX_B) begin
                        burst_cnt_d = burst_cnt_q + 8'd1;
                    end
                    timer_d = BUSY_LD;
                    state_d = ST_WAIT_BUSY;
                end
            end
            ST_WAIT_BUSY: begin
                if (bus.tx_busy) begin
                    state_d = ST_WAIT_DONE;
                end else if (timer_q == '0) begin
                    tx_err_d      = 1'b1;
                    grant_valid_d = 1'b0;
                    state_d       = ST_RELEASE;
                end else begin
                    timer_d = timer_q - TW'(1);
                end
            end
            ST_WAIT_DONE: begin
                if (!bus.tx_busy) begin
                    if (last_f_q || (burst_cnt_q == MAX_B)) begin
                        grant_valid_d = 1'b0;
                        state_d       = ST_RELEASE;
                    end else begin
                        timer_d = IDLE_LD;
                        state_d = ST_GAP;
                    end
                end
            end
            ST_GAP: begin
                // Only the owner matters here; other requesters wait their turn.
                if (bus.req_valid[grant_id_q]) begin
                    state_d = ST_LOAD;
                end else if (timer_q == '0) begin
                    grant_valid_d = 1'b0;
                    state_d       = ST_RELEASE;
                end else begin
                    timer_d = timer_q - TW'(1);
                end
            end
            ST_RELEASE: begin
                rr_ptr_d = (grant_id_q == 2'(N_REQ - 1)) ? 2'd0 : grant_id_q + 2'd1;
                state_d  = ST_IDLE;
            end
            default: begin
                grant_valid_d = 1'b0;
                state_d       = ST_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge sclk) begin
        if (!reset) begin
            state_q       <= ST_IDLE;
            rr_ptr_q      <= '0;
            grant_id_q    <= '0;
            grant_valid_q <= 1'b0;
            burst_cnt_q   <= '0;
            timer_q       <= '0;
            last_f_q      <= 1'b0;
            tx_start_q    <= 1'b0;
            tx_data_q     <= '0;
            req_ready_q   <= '0;
            tx_err_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            rr_ptr_q      <= rr_ptr_d;
            grant_id_q    <= grant_id_d;
            grant_valid_q <= grant_valid_d;
            burst_cnt_q   <= burst_cnt_d;
            timer_q       <= timer_d;
            last_f_q      <= last_f_d;
            tx_start_q    <= tx_start_d;
            tx_data_q     <= tx_data_d;
            req_ready_q   <= req_ready_d;
            tx_err_q      <= tx_err_d;
        end
    end

    assign bus.req_ready   = req_ready_q;
    assign bus.tx_start    = tx_start_q;
    assign bus.tx_data     = tx_data_q;
    assign bus.grant_valid = grant_valid_q;
    assign bus.grant_id    = grant_id_q;
    assign bus.tx_err      = tx_err_q;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter. Two instances: g_dut[0] with MAX_BURST=16,
// g_dut[1] with MAX_BURST=2; both use IDLE_TMO=100, BUSY_TMO=4.
module tb_uart_tx_arbiter;
    localparam int N_REQ    = 4;
    localparam int BUSY_TMO = 4;
    localparam int IDLE_TMO = 100;

    logic        sclk;
    logic        rst_b;
    int unsigned cyc;
    int          n_checks;
    int          n_errors;
    int          busy_len;
    bit          busy_en;
    logic [9:0]  exp_q[$];

    initial begin
        sclk = 1'b0;
        forever #10 sclk = ~sclk;
    end

    initial begin
        cyc = 0;
        forever begin
            @(posedge sclk);
            cyc++;
        end
    end

    for (genvar k = 0; k < 2; k++) begin : g_dut
        uart_tx_arbiter_if #(.N_REQ(N_REQ)) bus ();

        uart_tx_arbiter #(
            .N_REQ    (N_REQ),
            .MAX_BURST(k == 0 ? 16 : 2),
            .IDLE_TMO (IDLE_TMO),
            .BUSY_TMO (BUSY_TMO)
        ) dut (
            .sclk (sclk),
            .reset(rst_b),
            .bus  (bus)
        );

        logic [8:0]  srcq [N_REQ][$];
        logic [9:0]  log_q[$];
        logic        busy;
        int          busy_cnt;
        bit          start_pend;
        bit          gv_prev;
        int unsigned busy_fall, gv_fall, start_cyc, err_cyc;
        int          err_cnt, ready_bad, starts_in_busy;

        assign bus.tx_busy = busy;

        // Monitor, uart_tx busy model and requester sources, all at the falling edge.
        initial begin
            busy = 1'b0; busy_cnt = 0; start_pend = 1'b0; gv_prev = 1'b0;
            busy_fall = 0; gv_fall = 0; start_cyc = 0; err_cyc = 0;
            err_cnt = 0; ready_bad = 0; starts_in_busy = 0;
            bus.req_valid = '0; bus.req_data = '0; bus.req_last = '0;
            forever begin
                @(negedge sclk);
                if (bus.tx_start) begin
                    log_q.push_back({bus.grant_id, bus.tx_data});
                    start_cyc = cyc;
                    if (busy) starts_in_busy++;
                    if (bus.req_ready != (4'b0001 << bus.grant_id)) ready_bad++;
                end else if (bus.req_ready != '0) begin
                    ready_bad++;
                end
                if (bus.tx_err) begin
                    err_cyc = cyc;
                    err_cnt++;
                end
                if (gv_prev && !bus.grant_valid) gv_fall = cyc;
                gv_prev = bus.grant_valid;

                if (busy_cnt > 0) begin
                    busy_cnt--;
                    if (busy_cnt == 0) begin
                        busy      = 1'b0;
                        busy_fall = cyc;
                    end
                end
                if (start_pend) begin
                    start_pend = 1'b0;
                    if (busy_en) begin
                        busy     = 1'b1;
                        busy_cnt = busy_len;
                    end
                end
                if (bus.tx_start) start_pend = 1'b1;

                for (int i = 0; i < N_REQ; i++) begin
                    if (bus.req_ready[i] && srcq[i].size() != 0) void'(srcq[i].pop_front());
                end
                for (int i = 0; i < N_REQ; i++) begin
                    if (srcq[i].size() != 0) begin
                        bus.req_valid[i]       = 1'b1;
                        bus.req_data[8*i +: 8] = srcq[i][0][7:0];
                        bus.req_last[i]        = srcq[i][0][8];
                    end else begin
                        bus.req_valid[i] = 1'b0;
                        bus.req_last[i]  = 1'b0;
                    end
                end
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic push(input int k, input int i, input bit last, input logic [7:0] data);
        if (k == 0) g_dut[0].srcq[i].push_back({last, data});
        else        g_dut[1].srcq[i].push_back({last, data});
    endtask

    task automatic expect_tx(input int id, input logic [7:0] data);
        exp_q.push_back({2'(id), data});
    endtask

    task automatic check_log(input int k, input string tag);
        logic [9:0] got[$];
        if (k == 0) begin
            got = g_dut[0].log_q;
            g_dut[0].log_q.delete();
        end else begin
            got = g_dut[1].log_q;
            g_dut[1].log_q.delete();
        end
        check({tag, " frame count"}, got.size(), exp_q.size());
        for (int j = 0; j < exp_q.size(); j++) begin
            check($sformatf("%s frame%0d {id,data}", tag, j),
                  (j < got.size()) ? got[j] : 10'h3FF, exp_q[j]);
        end
        exp_q.delete();
    endtask

    function automatic bit grant_of(input int k);
        return (k == 0) ? g_dut[0].bus.grant_valid : g_dut[1].bus.grant_valid;
    endfunction

    function automatic bit is_quiet(input int k);
        if (k == 0) begin
            if (g_dut[0].bus.grant_valid || g_dut[0].busy) return 1'b0;
            for (int i = 0; i < N_REQ; i++) if (g_dut[0].srcq[i].size() != 0) return 1'b0;
        end else begin
            if (g_dut[1].bus.grant_valid || g_dut[1].busy) return 1'b0;
            for (int i = 0; i < N_REQ; i++) if (g_dut[1].srcq[i].size() != 0) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic wait_quiet(input int k, input int budget, input string tag);
        int run;
        int n;
        run = 0;
        n   = 0;
        while (run < 5 && n < budget) begin
            @(negedge sclk);
            n++;
            run = is_quiet(k) ? run + 1 : 0;
        end
        check({tag, " drained in budget"}, run >= 5, 1);
    endtask

    task automatic wait_grant(input int k, input int budget, input string tag);
        int n;
        n = 0;
        while (!grant_of(k) && n < budget) begin
            @(negedge sclk);
            n++;
        end
        check({tag, " granted"}, grant_of(k), 1);
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, " tx_start"},    g_dut[0].bus.tx_start, 0);
        check({tag, " tx_data"},     g_dut[0].bus.tx_data, 0);
        check({tag, " req_ready"},   g_dut[0].bus.req_ready, 0);
        check({tag, " grant_valid"}, g_dut[0].bus.grant_valid, 0);
        check({tag, " grant_id"},    g_dut[0].bus.grant_id, 0);
        check({tag, " tx_err"},      g_dut[0].bus.tx_err, 0);
    endtask

    initial begin
        int          n;
        int unsigned t0, t1;
        n_checks = 0;
        n_errors = 0;
        busy_en  = 1'b1;
        busy_len = 4340;
        rst_b    = 1'b0;
        repeat (3) @(negedge sclk);
        check_outputs_zero("reset");
        rst_b = 1'b1;
        @(negedge sclk);

        // Single-byte packet with a full-length frame; grant drops one cycle after busy.
        push(0, 0, 1'b1, 8'hA7);
        wait_quiet(0, 6000, "t1");
        expect_tx(0, 8'hA7);
        check_log(0, "t1");
        check("t1 grant drop after busy fall", g_dut[0].gv_fall - g_dut[0].busy_fall, 1);

        busy_len = 40;

        // rr_ptr=1: req0 and req2 together -> 2 then 0.
        push(0, 0, 1'b1, 8'h10);
        push(0, 2, 1'b1, 8'h20);
        wait_quiet(0, 500, "t2 rr1");
        expect_tx(2, 8'h20);
        expect_tx(0, 8'h10);
        check_log(0, "t2 rr1");

        // req3 alone moves rr_ptr to 0; then req0 and req2 together -> 0 then 2.
        push(0, 3, 1'b1, 8'h30);
        wait_quiet(0, 500, "t2 req3");
        push(0, 0, 1'b1, 8'h11);
        push(0, 2, 1'b1, 8'h21);
        wait_quiet(0, 500, "t2 rr0");
        expect_tx(3, 8'h30);
        expect_tx(0, 8'h11);
        expect_tx(2, 8'h21);
        check_log(0, "t2 rr0");

        // Three-byte packet from req1 holds the grant while req3 waits.
        push(0, 1, 1'b0, 8'hA7);
        push(0, 1, 1'b0, 8'hC9);
        push(0, 1, 1'b1, 8'h55);
        wait_grant(0, 50, "t3");
        push(0, 3, 1'b1, 8'h3C);
        wait_quiet(0, 1000, "t3");
        expect_tx(1, 8'hA7);
        expect_tx(1, 8'hC9);
        expect_tx(1, 8'h55);
        expect_tx(3, 8'h3C);
        check_log(0, "t3");

        // Unfinished packet: GAP lasts IDLE_TMO cycles after the busy fall is seen.
        push(0, 1, 1'b0, 8'hC9);
        wait_grant(0, 50, "t4");
        push(0, 2, 1'b1, 8'h42);
        n = 0;
        while (!g_dut[0].busy && n < 100) begin @(negedge sclk); n++; end
        n = 0;
        while (g_dut[0].busy && n < 200) begin @(negedge sclk); n++; end
        n = 0;
        while (g_dut[0].bus.grant_valid && n < 300) begin @(negedge sclk); n++; end
        t1 = cyc;
        t0 = g_dut[0].busy_fall;
        check("t4 idle timeout release", t1 - t0, IDLE_TMO + 1);
        wait_quiet(0, 500, "t4");
        expect_tx(1, 8'hC9);
        expect_tx(2, 8'h42);
        check_log(0, "t4");

        // uart_tx never answers: tx_err per frame, grant moves on.
        busy_en = 1'b0;
        g_dut[0].err_cnt = 0;
        push(0, 0, 1'b1, 8'h50);
        push(0, 1, 1'b1, 8'h51);
        wait_quiet(0, 300, "t5");
        expect_tx(0, 8'h50);
        expect_tx(1, 8'h51);
        check_log(0, "t5");
        check("t5 tx_err pulses", g_dut[0].err_cnt, 2);
        check("t5 tx_err delay", g_dut[0].err_cyc - g_dut[0].start_cyc, BUSY_TMO);
        busy_en = 1'b1;

        // Reset in WAIT_DONE; next grant must wait for the old frame to finish.
        busy_len = 300;
        g_dut[0].starts_in_busy = 0;
        push(0, 0, 1'b1, 8'h66);
        n = 0;
        while (!g_dut[0].busy && n < 50) begin @(negedge sclk); n++; end
        repeat (5) @(negedge sclk);
        rst_b = 1'b0;
        @(negedge sclk);
        check_outputs_zero("t6 reset");
        push(0, 0, 1'b1, 8'h5A);
        @(negedge sclk);
        rst_b = 1'b1;
        wait_quiet(0, 1500, "t6");
        expect_tx(0, 8'h66);
        expect_tx(0, 8'h5A);
        check_log(0, "t6");
        check("t6 starts while busy", g_dut[0].starts_in_busy, 0);

        // MAX_BURST=2 instance: A7,C9 then req3, then 55.
        busy_len = 40;
        push(1, 1, 1'b0, 8'hA7);
        push(1, 1, 1'b0, 8'hC9);
        push(1, 1, 1'b1, 8'h55);
        wait_grant(1, 50, "t3b");
        push(1, 3, 1'b1, 8'h3C);
        wait_quiet(1, 1000, "t3b");
        expect_tx(1, 8'hA7);
        expect_tx(1, 8'hC9);
        expect_tx(3, 8'h3C);
        expect_tx(1, 8'h55);
        check_log(1, "t3b");

        check("dut0 req_ready pulses", g_dut[0].ready_bad, 0);
        check("dut1 req_ready pulses", g_dut[1].ready_bad, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
